fir_coef_sequencer: RTL
=======================

// Module: fir_coef_sequencer
// PURPOSE
//  Controller that sequences the 25-tap FIR datapath (8-bit samples, 16-bit coefs, serial coef shift-in
//  via load_c). Host writes coefs into a shadow bank by address; a commit pulse replays the bank into the
//  filter (TAPS load_c cycles), clears the filter's sample line, then streams samples and flags valid outputs.
// PARAMETERS
//  TAPS       25  filter length; must equal the filter's TAPS
//  COEF_W     16  coefficient width
//  DATA_W      8  sample width
//  ADDR_W      5  shadow-bank address width, 2**ADDR_W >= TAPS
// PORTS
//  clk          in   1       clock; all logic on posedge
//  reset        in   1       synchronous, active-low reset
//  cfg_wr       in   1       write shadow[cfg_addr] <= cfg_wdata
//  cfg_addr     in   ADDR_W  shadow index (tap k)
//  cfg_wdata    in   COEF_W  coefficient value
//  cfg_commit   in   1       pulse: replay shadow bank into filter
//  cfg_busy     out  1       high in LOAD and FLUSH
//  cfg_err      out  1       sticky: write/commit rejected (busy or addr>=TAPS)
//  cfg_rdata    out  COEF_W  shadow readback (see CONFIGURATION)
//  in_valid     in   1       sample present
//  in_data      in   DATA_W  sample
//  in_ready     out  1       high only in RUN
//  underflow    out  1       sticky: in_valid low during a RUN cycle
//  out_valid    out  1       filter data_out holds a full-window result
//  fir_reset    out  1       to filter reset (active-high)
//  fir_load_c   out  1       to filter load_c
//  fir_coef_in  out  COEF_W  to filter coef_in
//  fir_data_in  out  DATA_W  to filter data_in
// BEHAVIOUR
//  - FSM: IDLE -> LOAD -> FLUSH -> RUN; RUN -> LOAD on cfg_commit. All outputs registered except in_ready.
//  - Reset (reset==0 at edge): state=IDLE, shadow bank cleared to 0, cfg_err=0, underflow=0, out_valid=0,
//    fir_load_c=0, fir_reset=1, fir_coef_in=0, fir_data_in=0, cfg_rdata=0. Reset mid-LOAD aborts; filter coefs
//    are then undefined until next commit.
//  - IDLE: fir_reset=1 continuously; in_ready=0; cfg_commit -> LOAD.
//  - LOAD: exactly TAPS cycles, fir_load_c=1, fir_reset=0; cycle j (0..TAPS-1) drives
//    fir_coef_in=shadow[TAPS-1-j], so shadow[k] lands in filter tap k. Then -> FLUSH.
//  - FLUSH: 1 cycle, fir_reset=1, fir_load_c=0; clears run counter. -> RUN.
//  - fir_reset and fir_load_c are never high in the same cycle.
//  - RUN: in_ready=1; fir_data_in = in_valid ? in_data : 0 (zero bubble, sets underflow).
//    Filter shifts one sample every RUN cycle; no stall exists.
//  - Latency: sample driven in RUN cycle n contributes to data_out visible in cycle n+3.
//  - out_valid: run_cnt counts RUN cycles from 1, saturating at TAPS+3; out_valid=1 in every RUN cycle
//    with run_cnt >= TAPS+3 (first window fully loaded with fresh samples and new coefs); 0 elsewhere.
//  - cfg_wr in IDLE/RUN writes shadow; the next commit uses it; the filter is unaffected until commit.
//  - cfg_wr or cfg_commit while cfg_busy: ignored, cfg_err<=1. cfg_addr>=TAPS: ignored, cfg_err<=1.
//  - cfg_wr and cfg_commit same cycle (not busy): write applies first; LOAD uses the new value.
//  - cfg_commit in RUN: in_ready drops the next cycle; out_valid drops with it; in-flight outputs discarded.
//  - cfg_err/underflow clear only on reset.
// CONFIGURATION
//  FIR_COEF_SEQ_READBACK_EN defined: cfg_rdata <= shadow[cfg_addr] every cycle (1-cycle latency,
//    0 for addr>=TAPS). Not defined: cfg_rdata tied to 0, no read mux synthesised. Port list identical.
// TESTING
//  1 reset low 2 cycles -> fir_reset=1, fir_load_c=0, out_valid=0, in_ready=0, cfg_busy=0.
//  2 write shadow[k]=k+1 (k=0..24), commit -> 25 cycles fir_load_c=1 with fir_coef_in 25,24..1,
//    then 1 cycle fir_reset=1, then in_ready=1; filter tap k reads k+1.
//  3 coefs as 2, RUN with impulse 1 then zeros -> out_valid rises at run_cnt=28; data_out walks
//    h[k]=k+1 tap by tap; constant in_data=1 -> data_out=325.
//  4 cfg_wr and commit during LOAD -> ignored, cfg_err=1, load sequence unchanged (25 cycles).
//  5 in_valid low 1 cycle in RUN -> fir_data_in=0, underflow=1 sticky until reset.
//  6 commit mid-RUN, reset low at LOAD cycle 10 -> IDLE next cycle, fir_reset=1, shadow zeroed.

Source files
------------

// File: rtl/fir_coef_sequencer.sv
// Coefficient/sample sequencer for a serially-loaded TAPS-tap FIR datapath.
// Optional shadow readback port enabled by defining FIR_COEF_SEQ_READBACK_EN.
module fir_coef_sequencer #(
  parameter int unsigned TAPS   = 25,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [COEF_W-1:0] cfg_wdata,
  input  logic              cfg_commit,
  output logic              cfg_busy,
  output logic              cfg_err,
  output logic [COEF_W-1:0] cfg_rdata,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              underflow,
  output logic              out_valid,
  output logic              fir_reset,
  output logic              fir_load_c,
  output logic [COEF_W-1:0] fir_coef_in,
  output logic [DATA_W-1:0] fir_data_in
);

  localparam int unsigned IdxW     = $clog2(TAPS);
  localparam int unsigned LoadCntW = $clog2(TAPS + 1);
  localparam int unsigned RunFull  = TAPS + 3;
  localparam int unsigned RunCntW  = $clog2(RunFull + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StRun} state_e;

  state_e              state_q;
  logic [COEF_W-1:0]   shadow_q [TAPS];
  logic [LoadCntW-1:0] load_cnt_q;
  logic [RunCntW-1:0]  run_cnt_q;
  logic                busy_q;
  logic                err_q;
  logic                underflow_q;
  logic                out_valid_q;
  logic                fir_reset_q;
  logic                load_c_q;
  logic [COEF_W-1:0]   coef_q;
  logic [DATA_W-1:0]   data_q;

  logic              busy;
  logic              addr_ok;
  logic              wr_ok;
  logic              start_load;
  logic              err_set;
  logic [IdxW-1:0]   wr_idx;
  logic [IdxW-1:0]   load_idx;
  logic [COEF_W-1:0] first_coef;

  always_comb begin
    busy       = (state_q == StLoad) || (state_q == StFlush);
    addr_ok    = 32'(cfg_addr) < TAPS;
    wr_idx     = IdxW'(cfg_addr);
    wr_ok      = cfg_wr && !busy && addr_ok;
    start_load = cfg_commit && !busy;
    err_set    = (busy && (cfg_wr || cfg_commit)) || (cfg_wr && !addr_ok);
    // Tap TAPS-1 goes out first, so shadow[k] ends up in filter tap k after TAPS shifts.
    load_idx   = IdxW'(TAPS - 1 - 32'(load_cnt_q));
    // A write landing in the commit cycle must be visible to the very first load beat.
    first_coef = (wr_ok && (32'(cfg_addr) == TAPS - 1)) ? cfg_wdata
                                                        : shadow_q[IdxW'(TAPS - 1)];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      for (int unsigned k = 0; k < TAPS; k++) shadow_q[k] <= '0;
      load_cnt_q  <= '0;
      run_cnt_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      underflow_q <= 1'b0;
      out_valid_q <= 1'b0;
      fir_reset_q <= 1'b1;
      load_c_q    <= 1'b0;
      coef_q      <= '0;
      data_q      <= '0;
    end else begin
      if (wr_ok) shadow_q[wr_idx] <= cfg_wdata;
      if (err_set) err_q <= 1'b1;
      if (state_q == StRun && !in_valid) underflow_q <= 1'b1;
      data_q <= (state_q == StRun && in_valid) ? in_data : '0;

      if (start_load) begin
        state_q     <= StLoad;
        busy_q      <= 1'b1;
        load_c_q    <= 1'b1;
        fir_reset_q <= 1'b0;
        coef_q      <= first_coef;
        load_cnt_q  <= LoadCntW'(1);
        run_cnt_q   <= '0;
        out_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            fir_reset_q <= 1'b1;
            out_valid_q <= 1'b0;
          end
          StLoad: begin
            if (32'(load_cnt_q) == TAPS) begin
              state_q     <= StFlush;
              load_c_q    <= 1'b0;
              fir_reset_q <= 1'b1;
            end else begin
              coef_q     <= shadow_q[load_idx];
              load_cnt_q <= load_cnt_q + LoadCntW'(1);
            end
          end
          StFlush: begin
            state_q     <= StRun;
            busy_q      <= 1'b0;
            fir_reset_q <= 1'b0;
            run_cnt_q   <= RunCntW'(1);
            out_valid_q <= 1'b0;
          end
          StRun: begin
            if (32'(run_cnt_q) != RunFull) run_cnt_q <= run_cnt_q + RunCntW'(1);
            // Registered flag tracks the run count of the cycle it will be visible in.
            out_valid_q <= 32'(run_cnt_q) >= RunFull - 1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef FIR_COEF_SEQ_READBACK_EN
  logic [COEF_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= addr_ok ? shadow_q[wr_idx] : '0;
    end
  end

  assign cfg_rdata = rdata_q;
`else
  assign cfg_rdata = '0;
`endif

  assign in_ready    = (state_q == StRun);
  assign cfg_busy    = busy_q;
  assign cfg_err     = err_q;
  assign underflow   = underflow_q;
  assign out_valid   = out_valid_q;
  assign fir_reset   = fir_reset_q;
  assign fir_load_c  = load_c_q;
  assign fir_coef_in = coef_q;
  assign fir_data_in = data_q;

endmodule
